// File: rtl/comparator_16.sv
// 16-bit unsigned magnitude comparator built from four cascaded 4-bit slices,
// with combinational one-hot great/equal/less results and a registered copy.
module comparator_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        greatin,
  input  logic        equalin,
  input  logic        lessin,
  output logic        great,
  output logic        equal,
  output logic        less,
  output logic        great_q,
  output logic        equal_q,
  output logic        less_q
);

  localparam int unsigned NumSlices = 4;

  // Cascade bus: index 0 is the external input, index i+1 is the output of slice i.
  logic [NumSlices:0] gt_c;
  logic [NumSlices:0] eq_c;
  logic [NumSlices:0] lt_c;

  assign gt_c[0] = greatin;
  assign eq_c[0] = equalin;
  assign lt_c[0] = lessin;

  for (genvar i = 0; i < NumSlices; i++) begin : g_slice
    logic [3:0] a_s;
    logic [3:0] b_s;

    assign a_s = a[4*i +: 4];
    assign b_s = b[4*i +: 4];

    // A tied slice defers to the cascade. In that case equal beats great, which
    // beats less, and an all-zero cascade resolves to equal.
    always_comb begin
      gt_c[i+1] = 1'b0;
      eq_c[i+1] = 1'b0;
      lt_c[i+1] = 1'b0;
      if (a_s > b_s) begin
        gt_c[i+1] = 1'b1;
      end else if (a_s < b_s) begin
        lt_c[i+1] = 1'b1;
      end else if (eq_c[i]) begin
        eq_c[i+1] = 1'b1;
      end else if (gt_c[i]) begin
        gt_c[i+1] = 1'b1;
      end else if (lt_c[i]) begin
        lt_c[i+1] = 1'b1;
      end else begin
        eq_c[i+1] = 1'b1;
      end
    end
  end

  assign great = gt_c[NumSlices];
  assign equal = eq_c[NumSlices];
  assign less  = lt_c[NumSlices];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      great_q <= 1'b0;
      equal_q <= 1'b1;
      less_q  <= 1'b0;
    end else begin
      great_q <= great;
      equal_q <= equal;
      less_q  <= less;
    end
  end

endmodule

// File: tb/tb_comparator_16.sv
// Self-checking bench for comparator_16: directed vectors, a small sweep,
// reset behaviour and a randomized check of the registered outputs.
module tb_comparator_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        greatin;
  logic        equalin;
  logic        lessin;
  logic        great;
  logic        equal;
  logic        less;
  logic        great_q;
  logic        equal_q;
  logic        less_q;

  int unsigned n_tests;
  int unsigned n_fail;

  comparator_16 u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .greatin (greatin),
    .equalin (equalin),
    .lessin  (lessin),
    .great   (great),
    .equal   (equal),
    .less    (less),
    .great_q (great_q),
    .equal_q (equal_q),
    .less_q  (less_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Values are {great, equal, less}.
  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got gel=%b expected gel=%b (a=%h b=%h casc=%b%b%b)",
               tag, got, exp, a, b, greatin, equalin, lessin);
    end
  endtask

  // Reference: magnitude first, then cascade priority equal > great > less > none(equal).
  function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] casc);
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    if (casc[1]) return 3'b010;
    if (casc[2]) return 3'b100;
    if (casc[0]) return 3'b001;
    return 3'b010;
  endfunction

  // casc is {greatin, equalin, lessin}.
  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] casc);
    a       = va;
    b       = vb;
    greatin = casc[2];
    equalin = casc[1];
    lessin  = casc[0];
  endtask

  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [2:0] casc, input logic [2:0] exp);
    drive(va, vb, casc);
    #1;
    check_eq(tag, {great, equal, less}, exp);
  endtask

  logic [2:0] prev_exp;
  logic [2:0] casc_r;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(16'h0000, 16'h0000, 3'b010);

    // Reset state of the registers.
    @(posedge clk);
    #1;
    check_eq("reset_regs", {great_q, equal_q, less_q}, 3'b010);

    // Directed vectors with hand-computed results.
    run_vec("msb_gt",        16'h8000, 16'h7FFF, 3'b010, 3'b100);
    run_vec("msb_lt",        16'h7FFF, 16'h8000, 3'b010, 3'b001);
    run_vec("eq_casc_gt",    16'h1234, 16'h1234, 3'b100, 3'b100);
    run_vec("eq_casc_lt",    16'h1234, 16'h1234, 3'b001, 3'b001);
    run_vec("eq_casc_none",  16'h1234, 16'h1234, 3'b000, 3'b010);
    run_vec("eq_casc_eq",    16'h1234, 16'h1234, 3'b010, 3'b010);
    run_vec("eq_prio_eq_gt", 16'h1234, 16'h1234, 3'b110, 3'b010);
    run_vec("eq_prio_eq_lt", 16'h5555, 16'h5555, 3'b011, 3'b010);
    run_vec("eq_prio_gt_lt", 16'h1234, 16'h1234, 3'b101, 3'b100);
    run_vec("ffff_vs_0",     16'hFFFF, 16'h0000, 3'b001, 3'b100);
    run_vec("0_vs_ffff",     16'h0000, 16'hFFFF, 3'b100, 3'b001);
    run_vec("slice1_wins",   16'h0010, 16'h0001, 3'b001, 3'b100);
    run_vec("slice3_wins",   16'h1000, 16'h0FFF, 3'b010, 3'b100);
    run_vec("slice2_lt",     16'h00F0, 16'h0100, 3'b010, 3'b001);
    run_vec("slice0_lt",     16'hABCD, 16'hABCE, 3'b100, 3'b001);
    run_vec("slice2_gt",     16'h0A00, 16'h09FF, 3'b001, 3'b100);

    // Low-range sweep with neutral cascade: comb outputs are unaffected by reset.
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        drive(16'(i), 16'(j), 3'b010);
        #11;
        check_eq("sweep", {great, equal, less}, ref_cmp(16'(i), 16'(j), 3'b010));
      end
    end

    // Reset holds the registers while comb outputs keep working; then load.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(16'd5, 16'd3, 3'b010);
    @(posedge clk);
    #1;
    check_eq("rst_regs", {great_q, equal_q, less_q}, 3'b010);
    check_eq("rst_comb", {great, equal, less}, 3'b100);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_load", {great_q, equal_q, less_q}, 3'b100);
    drive(16'd3, 16'd5, 3'b010);
    @(posedge clk);
    #1;
    check_eq("reg_load_lt", {great_q, equal_q, less_q}, 3'b001);

    // Random stimulus: each register value equals the previous cycle's result.
    prev_exp = 3'b001;
    for (int k = 0; k < 400; k++) begin
      casc_r = 3'($urandom_range(0, 7));
      if (k % 4 == 0) drive(16'($urandom), 16'($urandom), casc_r);
      else begin
        a = 16'($urandom);
        drive(a, a, casc_r);
      end
      #1;
      check_eq("rand_comb", {great, equal, less}, ref_cmp(a, b, casc_r));
      @(posedge clk);
      #1;
      check_eq("rand_reg", {great_q, equal_q, less_q}, ref_cmp(a, b, casc_r));
      prev_exp = ref_cmp(a, b, casc_r);
    end

    // Mid-operation reset overrides a pending "greater" load.
    drive(16'hFFFF, 16'h0000, 3'b000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst", {great_q, equal_q, less_q}, 3'b010);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_resume", {great_q, equal_q, less_q}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
